sram_sp_arb2_ctrl: RTL
======================

Name: sram_sp_arb2_ctrl

Overview:
- Shares the single-port 16384x32 byte-enable SRAM macro between two requesters: port 0 (instruction fetch) and port 1 (data/debug).
- Requesters use a req/gnt/rvalid protocol with active-high byte enables; the block drives the macro's active-low CEN/GWEN/BEN pins.
- After reset, an optional init sequencer zero-fills the whole array before any grant is issued.
- Sits between the core/bus-side memory ports and the macro wrapper inside the SoC memory subsystem.

Parameters:
- ADDR_WIDTH, 14, word address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8.
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = go straight to SERVE.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- init_done_o  out  1  high once init completes (or immediately after reset if INIT_EN=0)
- p0_req_i / p1_req_i  in  1  access request
- p0_gnt_o / p1_gnt_o  out  1  grant, combinational, same cycle as req
- p0_addr_i / p1_addr_i  in  ADDR_WIDTH  word address
- p0_we_i / p1_we_i  in  1  1 = write, 0 = read
- p0_be_i / p1_be_i  in  DATA_WIDTH/8  byte enables, active high
- p0_wdata_i / p1_wdata_i  in  DATA_WIDTH  write data
- p0_rvalid_o / p1_rvalid_o  out  1  response valid, one cycle after grant
- p0_rdata_o / p1_rdata_o  out  DATA_WIDTH  read data, qualified by rvalid
- sram_cen_o  out  1  macro chip enable, active low
- sram_gwen_o  out  1  macro global write enable, active low
- sram_ben_o  out  DATA_WIDTH/8  macro byte enable, active low
- sram_a_o  out  ADDR_WIDTH  macro address
- sram_d_o  out  DATA_WIDTH  macro write data
- sram_q_i  in  DATA_WIDTH  macro read data, valid the cycle after the access

Behaviour:
- FSM states:
  - INIT: entered on reset when INIT_EN=1.
  - SERVE: entered on reset when INIT_EN=0, and from INIT after its last write.
- While rst is high:
  - sram_cen_o=1, sram_gwen_o=1, sram_ben_o=all 1, sram_a_o=0, sram_d_o=0.
  - All gnt and rvalid outputs 0; init_done_o=0.
  - Init counter cleared to 0; RR pointer reset so port 0 wins the first contention.
- INIT:
  - Each cycle drives cen=0, gwen=0, ben=0, d=0, a=counter; counter increments.
  - On counter = 2**ADDR_WIDTH-1, the write completes and the FSM goes to SERVE next cycle. Total 2**ADDR_WIDTH cycles.
  - gnt held 0 for both ports regardless of req; init_done_o=0.
  - Reset asserted mid-init restarts init from address 0.
- SERVE:
  - init_done_o=1.
  - Exactly one grant per cycle at most; gnt=req & arbitration winner.
  - Single requester: granted immediately.
  - Both requesting: grant the port not granted most recently. The RR pointer updates on every grant, not only on contention.
- Macro pins while a grant is issued:
  - cen=0.
  - gwen=~we.
  - ben=~be on writes, all 0 on reads.
  - a and d taken from the granted port.
- Macro pins with no grant: cen=1, gwen=1, ben=all 1; a and d hold the last value, which saves toggling.
- Write with be=0 is still granted and passed through unchanged (no bytes written).
- Response:
  - pN_rvalid_o is registered: high exactly one cycle after pN_gnt_o for reads and writes alike.
  - Both rdata outputs are driven from sram_q_i. Value is meaningful only for a read with rvalid; write rvalid carries don't-care data.
- Back-to-back grants to the same port or to alternating ports are sustained at 1 access per cycle, with no bubble.
- A requester must hold req, addr, we, be and wdata stable until gnt. Dropping req before gnt is legal; no response is generated.

Decomposition:
- Package sram_arb_pkg:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - BE_WIDTH constant.
  - FSM enum {INIT, SERVE}.
  - Port-index constants.
- Sub-module rr_arb2:
  - Two-requester round-robin arbiter, combinational grant with a registered last-winner pointer.
  - Reused by other shared-memory blocks.

Test Plan:
- INIT_EN=1, release reset -> init_done_o rises after exactly 16384 cycles with gnt held 0 throughout; read of addr 0x3FFF then returns 0x00000000.
- Port 0 writes 0xDEADBEEF to 0x0010 with be=4'b1111, then port 1 writes 0x000000AA with be=4'b0001 to the same address, then port 0 reads -> rdata 0xDEADBEAA with rvalid exactly 1 cycle after gnt.
- Both ports hold req continuously for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1 with one macro access every cycle.
- Port 1 read of 0x1234 alone -> sram_cen_o=0, sram_gwen_o=1, sram_ben_o=4'b0000 that cycle; p1_rvalid_o=1 next cycle only, p0_rvalid_o stays 0.
- Assert rst at init counter 0x0800 -> all pins return to idle values immediately; after release, init restarts from address 0 and takes the full 16384 cycles.
- INIT_EN=0 -> init_done_o=1 in the first cycle after reset and a request in that cycle is granted.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbitration controller.
package sram_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 14;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BE_WIDTH       = DATA_WIDTH_DEF / 8;

  // Controller phases: zero-fill sequencer, then normal request service.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Requester indices, used for the arbiter's last-winner pointer.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_sp_arb2_ctrl_if.sv
// One requester's req/gnt/rvalid memory port. The requester drives the
// master side; the controller sits on the slave side.
interface sram_sp_arb2_ctrl_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, with a
// registered pointer to the most recent winner so that contention always
// goes to the other port.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_r;

  // Grant a lone requester outright; on contention grant the port that did not win last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_r == PORT1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Track the last winner on every grant; reset makes port 0 win the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= PORT1;
    end else if (gnt[0]) begin
      last_r <= PORT0;
    end else if (gnt[1]) begin
      last_r <= PORT1;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/sram_sp_arb2_ctrl.sv
// Shares one single-port byte-enable SRAM macro between an instruction-fetch
// port (p0) and a data/debug port (p1). After reset an optional sequencer
// zero-fills the whole array before any grant is issued.
module sram_sp_arb2_ctrl
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_done_o,
  sram_sp_arb2_ctrl_if.slave      p0,
  sram_sp_arb2_ctrl_if.slave      p1,
  output logic                    sram_cen_o,
  output logic                    sram_gwen_o,
  output logic [DATA_WIDTH/8-1:0] sram_ben_o,
  output logic [ADDR_WIDTH-1:0]   sram_a_o,
  output logic [DATA_WIDTH-1:0]   sram_d_o,
  input  logic [DATA_WIDTH-1:0]   sram_q_i
);

  localparam int                    BEW         = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam state_t                RESET_STATE = INIT_EN ? ST_INIT : ST_SERVE;

  state_t                state_r;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] a_hold_r;
  logic [DATA_WIDTH-1:0] d_hold_r;
  logic [1:0]            req_s;
  logic [1:0]            gnt_s;
  logic [1:0]            rvalid_r;
  logic                  serve_s;
  logic                  init_act_s;

  // Reset is folded in so that nothing is granted or driven while it is held,
  // even though the state register already sits at its reset value.
  assign serve_s    = (state_r == ST_SERVE) && !rst;
  assign init_act_s = (state_r == ST_INIT) && !rst;
  assign req_s      = {p1.req, p0.req};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (serve_s),
    .req (req_s),
    .gnt (gnt_s)
  );

  assign init_done_o = serve_s;
  assign p0.gnt      = gnt_s[0];
  assign p1.gnt      = gnt_s[1];
  assign p0.rvalid   = rvalid_r[0];
  assign p1.rvalid   = rvalid_r[1];
  assign p0.rdata    = sram_q_i;
  assign p1.rdata    = sram_q_i;

  // Phase register; reset selects zero-fill or direct service.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_next;
    end
  end

  // Leave the fill phase once the last address has been written.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_ADDR) begin
          state_next = ST_SERVE;
        end else begin
          state_next = ST_INIT;
        end
      end
      ST_SERVE: state_next = ST_SERVE;
      default:  state_next = ST_SERVE;
    endcase
  end

  // Fill address counter, advancing one word per cycle during the fill phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_INIT) begin
      cnt_r <= cnt_r + ADDR_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Macro pins: fill write, granted access, or idle with address/data parked.
  always_comb begin
    sram_cen_o  = 1'b1;
    sram_gwen_o = 1'b1;
    sram_ben_o  = {BEW{1'b1}};
    sram_a_o    = a_hold_r;
    sram_d_o    = d_hold_r;
    if (init_act_s) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = 1'b0;
      sram_ben_o  = {BEW{1'b0}};
      sram_a_o    = cnt_r;
      sram_d_o    = '0;
    end else if (gnt_s[0]) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = ~p0.we;
      sram_ben_o  = p0.we ? ~p0.be : {BEW{1'b0}};
      sram_a_o    = p0.addr;
      sram_d_o    = p0.wdata;
    end else if (gnt_s[1]) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = ~p1.we;
      sram_ben_o  = p1.we ? ~p1.be : {BEW{1'b0}};
      sram_a_o    = p1.addr;
      sram_d_o    = p1.wdata;
    end else begin
      sram_cen_o  = 1'b1;
      sram_gwen_o = 1'b1;
    end
  end

  // Park the last driven address and data so idle cycles do not toggle the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hold_r <= '0;
      d_hold_r <= '0;
    end else begin
      a_hold_r <= sram_a_o;
      d_hold_r <= sram_d_o;
    end
  end

  // Response valid follows each grant by exactly one cycle, reads and writes alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r <= 2'b00;
    end else begin
      rvalid_r <= gnt_s;
    end
  end

endmodule
